// File: rtl/cp_metric_sched_if.sv
// cp_metric_sched_if
//   Bundles the control, sample-stream and result signals of the CP-metric
//   scheduler so they travel as one port.
//   master : host / sync FSM side (drives start, abort, num_sym and the
//            sample stream; observes clear, status and peak results)
//   slave  : scheduler side (the reverse)
//   Signals:
//     start, abort, num_sym[7:0]        run control
//     sample_valid, metric_in[METRIC_W] sample stream and datapath metric
//     dp_clr                            synchronous clear to the datapath
//     busy, done, err, sym_count[7:0]   status
//     peak_idx[IDX_W], peak_val[METRIC_W] per-symbol search result
interface cp_metric_sched_if #(
  parameter int METRIC_W = 16,
  parameter int IDX_W    = 7
);
  logic                       start;
  logic                       abort;
  logic [7:0]                 num_sym;
  logic                       sample_valid;
  logic signed [METRIC_W-1:0] metric_in;
  logic                       dp_clr;
  logic                       busy;
  logic                       done;
  logic [IDX_W-1:0]           peak_idx;
  logic signed [METRIC_W-1:0] peak_val;
  logic [7:0]                 sym_count;
  logic                       err;

  modport master (
    output start, abort, num_sym, sample_valid, metric_in,
    input  dp_clr, busy, done, peak_idx, peak_val, sym_count, err
  );

  modport slave (
    input  start, abort, num_sym, sample_valid, metric_in,
    output dp_clr, busy, done, peak_idx, peak_val, sym_count, err
  );
endinterface

// File: rtl/cp_metric_sched.sv
// cp_metric_sched
//   Sequences the CP-correlation metric datapath. On start it clears the
//   datapath for one cycle, waits out pipeline latency plus window fill,
//   then runs an argmax search over each SYM_LEN-sample span of the metric
//   stream and reports peak index/value once per symbol.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset
//     bus  : cp_metric_sched_if.slave (run control, sample stream,
//            datapath clear, status and peak results)
//   All outputs are registered.
module cp_metric_sched #(
  parameter int L_WIN    = 16,
  parameter int PIPE_LAT = 7,
  parameter int SYM_LEN  = 80,
  parameter int METRIC_W = 16,
  parameter int IDX_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  cp_metric_sched_if.slave   bus
);

  // Number of valid samples needed before the first metric of a full window
  // appears at the datapath output.
  localparam int FILL_LEN = PIPE_LAT + L_WIN - 1;
  localparam int FILL_W   = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_FILL,
    S_SEARCH
  } state_t;

  state_t                     state_q, state_d;
  logic [FILL_W-1:0]          fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]           j_q, j_d;
  logic signed [METRIC_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]           best_idx_q, best_idx_d;
  logic signed [METRIC_W-1:0] peak_val_q, peak_val_d;
  logic [IDX_W-1:0]           peak_idx_q, peak_idx_d;
  logic [7:0]                 sym_count_q, sym_count_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       dp_clr_q, dp_clr_d;
  logic                       busy_q, busy_d;

  // The first sample of a span always seeds the best; later samples win
  // only on a strictly greater value so ties keep the earliest index.
  logic       take_new;
  logic [7:0] sym_count_inc;

  assign take_new      = (j_q == '0) || (bus.metric_in > best_val_q);
  assign sym_count_inc = (sym_count_q == 8'hFF) ? 8'hFF : sym_count_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    j_d         = j_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    peak_val_d  = peak_val_q;
    peak_idx_d  = peak_idx_q;
    sym_count_d = sym_count_q;
    err_d       = err_q;
    done_d      = 1'b0;

    if (bus.abort) begin
      // Abort overrides every other transition, including a completing
      // symbol: results and counters are simply held.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d     = S_CLR;
            err_d       = 1'b0;
            sym_count_d = 8'd0;
          end
        end

        S_CLR: begin
          // The sample presented during the clear cycle is discarded.
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end

        S_FILL: begin
          if (!bus.sample_valid) begin
            err_d   = 1'b1;
            state_d = S_CLR;
          end else if (fill_cnt_q == FILL_W'(FILL_LEN - 1)) begin
            state_d = S_SEARCH;
            j_d     = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end

        S_SEARCH: begin
          if (!bus.sample_valid) begin
            // A gap invalidates the window contents; the partial symbol is
            // dropped and the datapath is refilled from scratch.
            err_d   = 1'b1;
            state_d = S_CLR;
          end else begin
            if (take_new) begin
              best_val_d = bus.metric_in;
              best_idx_d = j_q;
            end
            if (j_q == IDX_W'(SYM_LEN - 1)) begin
              // Final result must include the last sample of the span, so
              // it is taken from the same selection as best_*_d.
              j_d         = '0;
              done_d      = 1'b1;
              peak_val_d  = take_new ? bus.metric_in : best_val_q;
              peak_idx_d  = take_new ? j_q : best_idx_q;
              sym_count_d = sym_count_inc;
              if ((bus.num_sym != 8'd0) && (sym_count_inc == bus.num_sym)) begin
                state_d = S_IDLE;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Moore outputs registered from the next state so they line up with it.
    dp_clr_d = (state_d == S_CLR);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fill_cnt_q  <= '0;
      j_q         <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      peak_val_q  <= '0;
      peak_idx_q  <= '0;
      sym_count_q <= 8'd0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      dp_clr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      j_q         <= j_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      peak_val_q  <= peak_val_d;
      peak_idx_q  <= peak_idx_d;
      sym_count_q <= sym_count_d;
      err_q       <= err_d;
      done_q      <= done_d;
      dp_clr_q    <= dp_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.dp_clr    = dp_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.peak_idx  = peak_idx_q;
  assign bus.peak_val  = peak_val_q;
  assign bus.sym_count = sym_count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cp_metric_sched.sv
// tb_cp_metric_sched
//   Drives acquisition runs with random and directed metric streams. A
//   driver pushes the expected per-symbol result (argmax computed directly
//   from the symbol's sample array) into a queue; a monitor pops and
//   compares whenever the scheduler raises done.
module tb_cp_metric_sched;

  localparam int FILL = 7 + 16 - 1;
  localparam int SYM  = 80;

  typedef struct {
    int cyc;
    int idx;
    int val;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic signed [15:0] sym_data [4][SYM];
  int model_count = 0;
  int last_idx = 0;
  int last_val = 0;
  int run_c0 = 0;
  int last_done_cyc = 0;

  cp_metric_sched_if #(.METRIC_W(16), .IDX_W(7)) bus();

  cp_metric_sched #(
    .L_WIN(16), .PIPE_LAT(7), .SYM_LEN(SYM), .METRIC_W(16), .IDX_W(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dp_clr"}, bus.dp_clr, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_peak_idx"}, bus.peak_idx, 0);
    check({tag, "_peak_val"}, bus.peak_val, 0);
    check({tag, "_sym_count"}, bus.sym_count, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  // Monitor: one line per completed symbol.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          last_done_cyc = cyc;
          $display("done cycle=%0d idx=%0d val=%0d count=%0d", cyc, bus.peak_idx,
                   bus.peak_val, bus.sym_count);
          check("done_cycle", cyc, e.cyc);
          check("peak_idx", bus.peak_idx, e.idx);
          check("peak_val", bus.peak_val, e.val);
          check("sym_count", bus.sym_count, e.cnt);
        end
      end
    end
  end

  task automatic fill_rand(input int s, input int lo, input int hi);
    for (int j = 0; j < SYM; j++)
      sym_data[s][j] = 16'(lo + int'($urandom_range(hi - lo, 0)));
  endtask

  // Reference: first index holding the maximum of the span.
  task automatic push_expected(input int s, input int done_cyc);
    exp_t e;
    int bi = 0;
    for (int k = 1; k < SYM; k++)
      if (sym_data[s][k] > sym_data[s][bi]) bi = k;
    model_count = (model_count >= 255) ? 255 : model_count + 1;
    e.cyc = done_cyc;
    e.idx = bi;
    e.val = int'(sym_data[s][bi]);
    e.cnt = model_count;
    last_idx = e.idx;
    last_val = e.val;
    exp_q.push_back(e);
  endtask

  // One clear cycle followed by the fill span; start pulses mid-fill and
  // must be ignored.
  task automatic clr_fill(input int expect_err);
    @(negedge clk);
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.metric_in = 16'($urandom);
    check("dp_clr_in_clr", bus.dp_clr, 1);
    check("busy_in_clr", bus.busy, 1);
    check("err_in_clr", bus.err, expect_err);
    for (int f = 0; f < FILL; f++) begin
      @(negedge clk);
      bus.start = (f == 5);
      bus.sample_valid = 1'b1;
      bus.metric_in = 16'($urandom);
      if (f == 0) check("dp_clr_after_clr", bus.dp_clr, 0);
    end
  endtask

  // stop_kind: 0 none, 1 abort at (stop_s, stop_j), 2 async reset there.
  task automatic run(input int nreg, input int nsyms, input int gap_s, input int gap_j,
                     input int stop_s, input int stop_j, input int stop_kind);
    int  s;
    bit  gapped;
    @(negedge clk);
    check("idle_before_start", bus.busy, 0);
    check("dp_clr_idle", bus.dp_clr, 0);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.num_sym = 8'(nreg);
    bus.sample_valid = 1'b1;
    bus.metric_in = 16'($urandom);
    run_c0 = cyc;
    model_count = 0;
    clr_fill(0);
    s = 0;
    while (s < nsyms) begin
      gapped = 1'b0;
      for (int j = 0; j < SYM; j++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.sample_valid = 1'b1;
        bus.metric_in = sym_data[s][j];
        if (s == gap_s && j == gap_j) begin
          bus.sample_valid = 1'b0;
          gapped = 1'b1;
          break;
        end
        if (stop_kind != 0 && s == stop_s && j == stop_j) begin
          if (stop_kind == 1) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            bus.sample_valid = 1'b0;
            check("abort_busy", bus.busy, 0);
            check("abort_dp_clr", bus.dp_clr, 0);
            check("abort_sym_count", bus.sym_count, model_count);
            check("abort_peak_idx", bus.peak_idx, last_idx);
            check("abort_peak_val", bus.peak_val, last_val);
            @(negedge clk);
            check("abort_done_none", bus.done, 0);
          end else begin
            #2 rst = 1'b1;
            #1 check_all_zero("async_rst");
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            bus.sample_valid = 1'b0;
            @(negedge clk);
            check("post_rst_busy", bus.busy, 0);
            check("post_rst_sym_count", bus.sym_count, 0);
            model_count = 0;
            last_idx = 0;
            last_val = 0;
          end
          return;
        end
        if (j == SYM - 1) push_expected(s, cyc + 1);
      end
      if (gapped) begin
        gap_s = -1;
        clr_fill(1);
      end else begin
        s++;
      end
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    check("end_busy", bus.busy, 0);
    check("end_sym_count", bus.sym_count, model_count);
    check("end_peak_idx", bus.peak_idx, last_idx);
    check("end_peak_val", bus.peak_val, last_val);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_sym = 8'd0;
    bus.sample_valid = 1'b0;
    bus.metric_in = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Basic search: single peak at j=37, first done 104 cycles after start.
    for (int j = 0; j < SYM; j++) sym_data[0][j] = 16'sh0010;
    sym_data[0][37] = 16'sh0400;
    run(1, 1, -1, 0, -1, 0, 0);
    check("basic_latency", last_done_cyc - run_c0, 104);
    check("basic_peak_val", bus.peak_val, 16'sh0400);

    // Negative metrics with a tied maximum of -5.
    for (int j = 0; j < SYM; j++) sym_data[0][j] = 16'(-int'($urandom_range(1000, 6)));
    sym_data[0][12] = -16'sd5;
    sym_data[0][60] = -16'sd5;
    run(1, 1, -1, 0, -1, 0, 0);
    check("tie_idx", bus.peak_idx, 12);

    // Three back-to-back symbols with peaks at the span edges.
    for (int s = 0; s < 3; s++) fill_rand(s, -2000, 2000);
    sym_data[0][5]  = 16'sd30000;
    sym_data[1][79] = 16'sd30000;
    sym_data[2][0]  = 16'sd30000;
    run(3, 3, -1, 0, -1, 0, 0);
    check("multi_last_done", last_done_cyc - run_c0, 264);

    // Stream gap at j=40 of the first symbol.
    fill_rand(0, -3000, 3000);
    run(1, 1, 0, 40, -1, 0, 0);
    check("gap_err_sticky", bus.err, 1);
    check("gap_latency", last_done_cyc - run_c0, 104 + 40 + 1 + FILL + 1);

    // Abort in continuous mode; err from the previous run clears on start.
    fill_rand(0, -100, 100);
    fill_rand(1, -100, 100);
    run(0, 2, -1, 0, 0, 50, 1);
    check("abort_err_cleared", bus.err, 0);

    // Randomised runs with small-range data (frequent ties) and gaps.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(3, 1));
      for (int s = 0; s < 3; s++) fill_rand(s, -8, 7);
      if ($urandom_range(1, 0) == 1)
        run(n, n, int'($urandom_range(n - 1, 0)), int'($urandom_range(SYM - 1, 0)), -1, 0, 0);
      else
        run(n, n, -1, 0, -1, 0, 0);
    end

    // Abort at a random point, possibly on a symbol-completing edge.
    fill_rand(0, -500, 500);
    fill_rand(1, -500, 500);
    run(0, 2, -1, 0, int'($urandom_range(1, 0)), int'($urandom_range(SYM - 1, 70)), 1);

    // Asynchronous reset mid-search of the second symbol.
    fill_rand(0, -500, 500);
    fill_rand(1, -500, 500);
    run(0, 3, -1, 0, 1, 30, 2);

    repeat (3) @(negedge clk);
    check("pending_done", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
